// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end for a small word-only data RAM.
// One request in flight at a time. Loads extract and extend a lane; sub-word
// stores do a read-modify-write, since the RAM only writes whole words.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for a request; faults are checked at acceptance
// S_READ  | RAM word addressed; load result or merged store word captured
// S_WRITE | single-cycle RAM write strobe
// S_RESP  | one-cycle completion pulse carrying rdata/err
module mem_access_unit #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [1:0]          r_lane;
  logic [31:0]         r_wdata;
  logic                r_err;
  logic [31:0]         r_rdata;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [31:0]         r_ram_wdata;
  logic                w_accept;
  logic                w_err;
  logic [31:0]         w_load;
  logic [31:0]         w_merged;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;

  assign w_accept = req_valid & (r_state == S_IDLE);

  // Fault detection on the live request fields (only used at acceptance)
  always_comb begin
    w_err = 1'b0;
    if (req_size == 2'b11)                          w_err = 1'b1;
    if ((req_size == 2'b01) && req_addr[0])         w_err = 1'b1;
    if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) w_err = 1'b1;
    if (req_addr[31:ADDR_W] != '0)                  w_err = 1'b1;
  end

  // Lane extraction and sign/zero extension of the RAM read word
  always_comb begin
    w_byte = ram_rdata[{r_lane, 3'b000} +: 8];
    w_half = ram_rdata[{r_lane[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load = ram_rdata;
    endcase
  end

  // Merge store data into the addressed lane, keeping the other bytes
  always_comb begin
    w_merged = ram_rdata;
    case (r_size)
      2'b00:   w_merged[{r_lane, 3'b000} +: 8]     = r_wdata[7:0];
      2'b01:   w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_merged = r_wdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err)                              w_next = S_RESP;
          else if (req_we && (req_size == 2'b10)) w_next = S_WRITE;
          else                                    w_next = S_READ;
        end
      end
      S_READ:  w_next = r_we ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the write strobe is masked by reset so no
  // RAM write happens at an edge where reset is asserted
  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
    ram_we     = (r_state == S_WRITE) & rst_n;
  end

  // Request capture, RAM address/data registers and response data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_lane      <= 2'b00;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      if (w_accept) begin
        r_we       <= req_we;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_lane     <= req_addr[1:0];
        r_wdata    <= req_wdata;
        r_err      <= w_err;
        r_rdata    <= '0;
        if (!w_err) begin
          r_ram_addr <= {req_addr[ADDR_W-1:2], 2'b00};
          if (req_we && (req_size == 2'b10)) r_ram_wdata <= req_wdata;
        end
      end else if (r_state == S_READ) begin
        if (r_we) r_ram_wdata <= w_merged;
        else      r_rdata     <= w_load;
      end
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural RAM and a response
// scoreboard (expected rdata/err/latency/write count queued per request).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [5:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;

  logic [31:0] mem [16];
  logic        mem_init;
  int          we_cnt;
  logic [31:0] last_wd;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wes;
    logic        chk_wd;
    logic [31:0] wd;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  assign ram_rdata = mem[ram_addr[5:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'h8077_F0A5;
      mem[5]  <= 32'h1234_5678;
      mem[8]  <= 32'hCAFE_BABE;
      mem[15] <= 32'h0BAD_F00D;
      we_cnt  <= 0;
      last_wd <= 32'h0;
    end else if (ram_we) begin
      mem[ram_addr[5:2]] <= ram_wdata;
      we_cnt  <= we_cnt + 1;
      last_wd <= ram_wdata;
    end
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] e_rd, input logic e_err, input int e_lat,
                        input int e_wes, input logic e_chk, input logic [31:0] e_wd,
                        input string tag);
    exp_t e;
    int lat;
    int w0;
    int guard;
    e.rdata = e_rd; e.err = e_err; e.lat = e_lat; e.wes = e_wes;
    e.chk_wd = e_chk; e.wd = e_wd;
    sb.push_back(e);
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk({31'b0, req_ready}, 32'd1, {tag, "_ready"});
    w0 = we_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom_range(3, 0)); req_we = 1'($urandom_range(1, 0));
    req_unsigned = 1'($urandom_range(1, 0));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 10);
    e = sb.pop_front();
    chk({31'b0, resp_valid}, 32'd1, {tag, "_resp_valid"});
    chk(resp_rdata, e.rdata, {tag, "_rdata"});
    chk({31'b0, resp_err}, {31'b0, e.err}, {tag, "_err"});
    chk(32'(lat), 32'(e.lat), {tag, "_latency"});
    chk(32'(we_cnt - w0), 32'(e.wes), {tag, "_we_pulses"});
    if (e.chk_wd) chk(last_wd, e.wd, {tag, "_wdata"});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc [3];
    int n;
    int cyc;
    int w0;
    logic [31:0] bb_addr [3];
    logic [31:0] bb_data [3];

    rst_n = 1'b0; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk({31'b0, req_ready}, 32'd1, "rst_ready");
    chk({31'b0, resp_valid}, 32'd0, "rst_resp_valid");
    chk({31'b0, resp_err}, 32'd0, "rst_resp_err");
    chk(resp_rdata, 32'h0, "rst_resp_rdata");
    chk({26'b0, ram_addr}, 32'h0, "rst_ram_addr");
    chk(ram_wdata, 32'h0, "rst_ram_wdata");
    chk({31'b0, ram_we}, 32'd0, "rst_ram_we");
    mem_init = 1'b0; rst_n = 1'b1;

    // loads from word 0x10 = 0x8077_F0A5
    do_req(0, 2'b00, 0, 32'h10, 0, 32'hFFFF_FFA5, 0, 2, 0, 0, 0, "ld_b10_s");
    do_req(0, 2'b01, 1, 32'h12, 0, 32'h0000_8077, 0, 2, 0, 0, 0, "ld_h12_u");
    do_req(0, 2'b00, 1, 32'h13, 0, 32'h0000_0080, 0, 2, 0, 0, 0, "ld_b13_u");
    do_req(0, 2'b01, 0, 32'h10, 0, 32'hFFFF_F0A5, 0, 2, 0, 0, 0, "ld_h10_s");
    do_req(0, 2'b00, 0, 32'h11, 0, 32'hFFFF_FFF0, 0, 2, 0, 0, 0, "ld_b11_s");
    do_req(0, 2'b00, 0, 32'h12, 0, 32'h0000_0077, 0, 2, 0, 0, 0, "ld_b12_s");

    // sub-word stores (read-modify-write) and read-back
    do_req(1, 2'b00, 0, 32'h11, 32'hAAAA_AA3C, 32'h0, 0, 3, 1, 1, 32'h8077_3CA5, "st_b11");
    do_req(0, 2'b10, 0, 32'h10, 0, 32'h8077_3CA5, 0, 2, 0, 0, 0, "ld_w10");
    do_req(1, 2'b01, 0, 32'h16, 32'h7777_BEEF, 32'h0, 0, 3, 1, 1, 32'hBEEF_5678, "st_h16");
    do_req(0, 2'b01, 0, 32'h16, 0, 32'hFFFF_BEEF, 0, 2, 0, 0, 0, "ld_h16_s");
    do_req(0, 2'b10, 0, 32'h14, 0, 32'hBEEF_5678, 0, 2, 0, 0, 0, "ld_w14");

    // faults: rdata must be cleared even after a non-zero load result
    do_req(1, 2'b10, 0, 32'h06, 32'h1111_1111, 32'h0, 1, 1, 0, 0, 0, "err_w06");
    do_req(0, 2'b10, 0, 32'h14, 0, 32'hBEEF_5678, 0, 2, 0, 0, 0, "ld_w14b");
    do_req(1, 2'b01, 0, 32'h03, 32'h2222_2222, 32'h0, 1, 1, 0, 0, 0, "err_h03");
    do_req(0, 2'b00, 0, 32'h40, 0, 32'h0, 1, 1, 0, 0, 0, "err_b40");
    do_req(0, 2'b11, 0, 32'h00, 0, 32'h0, 1, 1, 0, 0, 0, "err_sz3");
    do_req(0, 2'b10, 0, 32'h8000_0010, 0, 32'h0, 1, 1, 0, 0, 0, "err_hi");
    do_req(0, 2'b10, 0, 32'h04, 0, 32'h0, 0, 2, 0, 0, 0, "ld_w04");

    // word store at top of range
    do_req(1, 2'b10, 0, 32'h3C, 32'h5A5A_A5A5, 32'h0, 0, 2, 1, 1, 32'h5A5A_A5A5, "st_w3c");
    do_req(0, 2'b10, 0, 32'h3C, 0, 32'h5A5A_A5A5, 0, 2, 0, 0, 0, "ld_w3c");

    // reset during the WRITE cycle of a byte store to 0x21 (word 0xCAFE_BABE)
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h0000_0011; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({31'b0, ram_we}, 32'd1, "rstw_we_before");
    chk(ram_wdata, 32'hCAFE_11BE, "rstw_merged");
    w0 = we_cnt;
    rst_n = 1'b0;
    #1;
    chk({31'b0, ram_we}, 32'd0, "rstw_we_masked");
    @(negedge clk);
    rst_n = 1'b1;
    chk({31'b0, req_ready}, 32'd1, "rstw_ready");
    n = 0;
    repeat (4) begin
      if (resp_valid) n++;
      @(negedge clk);
    end
    chk(32'(n), 32'd0, "rstw_no_resp");
    chk(32'(we_cnt - w0), 32'd0, "rstw_no_write");
    chk(mem[8], 32'hCAFE_BABE, "rstw_mem_kept");

    // back-to-back word stores with req_valid held high
    bb_addr[0] = 32'h24; bb_data[0] = 32'h1111_0001;
    bb_addr[1] = 32'h28; bb_data[1] = 32'h2222_0002;
    bb_addr[2] = 32'h2C; bb_data[2] = 32'h3333_0003;
    w0 = we_cnt;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = bb_addr[0]; req_wdata = bb_data[0]; req_valid = 1'b1;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 40) begin
      if (req_ready) begin
        acc[n] = cyc;
        @(posedge clk);
        #1;
        n++;
        if (n < 3) begin
          req_addr = bb_addr[n]; req_wdata = bb_data[n];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk(32'(n), 32'd3, "b2b_accepts");
    if (n == 3) begin
      chk(32'(acc[1] - acc[0]), 32'd3, "b2b_gap01");
      chk(32'(acc[2] - acc[1]), 32'd3, "b2b_gap12");
    end
    repeat (3) @(negedge clk);
    chk(32'(we_cnt - w0), 32'd3, "b2b_writes");
    chk(mem[9],  32'h1111_0001, "b2b_mem24");
    chk(mem[10], 32'h2222_0002, "b2b_mem28");
    chk(mem[11], 32'h3333_0003, "b2b_mem2c");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
